execute_unit: RTL
=================

# execute_unit

Execute/write-back stage directly downstream of the fetch/decode stage. Accepts decoded fields plus the raw instruction word and reads two operands from an internal 32×32 register file. Performs the RV32I integer ALU operation, then writes the result back to `rd` one cycle later. Also provides a retired-instruction counter and a debug read port.

## Interface

Parameters:
- `XLEN`, 32: datapath width.
- `NREGS`, 32: register count (address width 5).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active low.
- `in_valid` in 1: decode fields valid this cycle.
- `in_ready` out 1: stage can accept; transfer on `in_valid && in_ready`.
- `instr` in 32: raw instruction word (immediate, funct7 source).
- `opcode` in 7: `instr[6:0]`.
- `rs1_addr` in 5: source register 1.
- `rs2_addr` in 5: source register 2.
- `rd_addr` in 5: destination register.
- `func` in 3: funct3.
- `res_valid` out 1: write-back stage occupied.
- `result` out 32: ALU result in write-back stage.
- `res_rd` out 5: destination of `result`.
- `res_wen` out 1: write-back will update the register file.
- `illegal` out 1: write-back instruction had an unsupported opcode.
- `retired` out 32: count of legal instructions written back.
- `dbg_addr` in 5: debug read address.
- `dbg_data` out 32: combinational register file read of `dbg_addr`; x0 reads 0.

## Operation

Two stages:
- **EX**: operand read + ALU, registered on transfer.
- **WB**: register-file write from the EX register.

Opcodes:
- `0110011` R-type. `func` 000 ADD/SUB, with SUB when `instr[30]`=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA when `instr[30]`=1), 110 OR, 111 AND.
- `0010011` I-type. Same `func` map. Operand B is `instr[31:20]` sign-extended. No SUB. SRAI when `instr[30]`=1.
- Any other opcode: accepted, `illegal`=1, `res_wen`=0, `result`=0, not counted.

Arithmetic rules:
- All arithmetic is modulo 2^32.
- Shift amount is B[4:0].
- SLT is signed; SLTU is unsigned. Both produce 0 or 1.

Register file:
- x0 always reads 0.
- Writes with `res_rd`=0 are suppressed: `res_wen`=0 and the register file is not written.
- `retired` increments on every WB cycle with a legal opcode, including rd=0. It wraps from 0xFFFFFFFF to 0.

Hazard: the WB instruction has `res_wen`=1 and `res_rd` matches `rs1_addr`, or matches `rs2_addr` for R-type only. Handling depends on `EXEC_BYPASS_EN` (see Configuration).

## Timing

- Transfer at edge T:
  - `res_valid`, `result`, `res_rd`, `res_wen` and `illegal` are valid during cycle T+1.
  - The register file is written at edge T+1.
  - `retired` shows the increment from cycle T+2.
- `res_valid` is high for exactly one cycle per transfer. Back-to-back transfers give continuous `res_valid`.
- No transfer: `res_valid`=0, `res_wen`=0, `illegal`=0. `result` and `res_rd` hold their previous value.
- `in_ready` is 1 except during a hazard stall (without bypass only). It is combinational from the inputs and the WB registers.
- `dbg_data` shows the old value during the write cycle and the new value after the edge.
- Reset, asserted any time:
  - `res_valid`, `res_wen` and `illegal` go to 0; `result` and `res_rd` to 0; `retired` to 0.
  - All registers are cleared to 0.
  - An in-flight write-back is discarded.
  - `in_ready` is 1 once reset deasserts.

## Configuration

`EXEC_BYPASS_EN` selects how a hazard is handled.
- **Defined**: EX takes the WB `result` for the matching operand. `in_ready` stays 1, giving a 1 instruction/cycle throughput.
- **Undefined**: `in_ready`=0 for the hazard cycle. The instruction transfers the next cycle and reads the updated register file. Each dependent back-to-back pair costs one bubble.

## Structure

- Package `exec_pkg`:
  - opcode constants `OP_RTYPE` and `OP_ITYPE`;
  - funct3 constants `F3_ADD` … `F3_AND`;
  - an `alu_op_t` enum;
  - `XLEN`.
- Sub-module `exec_regfile`:
  - 32×32, async-reset clear;
  - two operand read ports plus the debug read port;
  - one write port, with x0 hardwired.
- ALU and hazard logic live in `execute_unit`.

## Test plan

- **Reset**: assert `rst_n`=0 mid-stream → all outputs 0, `retired`=0, every `dbg_data` read returns 0.
- **Single ADDI**: ADDI x1,x0,5 then ADDI x2,x0,-3 → `result`=5 then 0xFFFFFFFD; `dbg_data`(x2)=0xFFFFFFFD two cycles after the second transfer; `retired`=2.
- **Dependent pair**: ADDI x1,x0,7 followed by ADD x3,x1,x1.
  - With `EXEC_BYPASS_EN`: no stall, `result`=14.
  - Without it: `in_ready`=0 for 1 cycle, `result`=14.
- **R-type ops**: x5=0x80000000, x6=4.
  - SRA → 0xF8000000; SRL → 0x08000000.
  - SLT x5,x6 → 1; SLTU → 0.
  - SUB x6,x5 → 0x80000004.
- **x0 and illegal**: ADDI x0,x0,9 → `res_wen`=0, x0 still reads 0, `retired`+1. Opcode 0x03 → `illegal`=1 for one cycle, no register write, `retired` unchanged.
- **Handshake**: `in_valid`=0 gaps between instructions → `res_valid` low in the gaps, and one write-back per transfer.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants and types for the execute/write-back stage.
// RV32I opcode/funct3 encodings and the internal ALU operation set.
package exec_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  // Map funct3 plus instr[30] to an ALU op; SUB exists only for R-type.
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic bit30,
                                         input logic is_r);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = (is_r && bit30) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SRL:  op = bit30 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// Integer register file: two operand read ports, one debug read port,
// one write port. x0 is hardwired to zero; the whole array clears on reset.
module exec_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd2,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next-state of the array: copy, then apply the single write (never to x0).
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != 5'd0)) regs_d[wa] = wd;
  end

  // Register array storage.
  // NOTE: this array is deliberately reset-cleared because architectural
  // state must read 0 after reset; a plain RAM would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd1      = (ra1 == 5'd0)      ? '0 : regs_q[ra1];
  assign rd2      = (ra2 == 5'd0)      ? '0 : regs_q[ra2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/execute_unit.sv
// Execute/write-back stage: operand read + RV32I ALU in EX, register-file
// write from the EX register in WB, retired-instruction counter.
// Optional macro EXEC_BYPASS_EN: forward the WB result into EX instead of
// stalling one cycle on a read-after-write hazard.
module execute_unit
  import exec_pkg::*;
#(
  parameter int XLEN  = exec_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [6:0]      opcode,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic [2:0]      func,
  output logic            res_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      res_rd,
  output logic            res_wen,
  output logic            illegal,
  output logic [31:0]     retired,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic            res_valid_q, res_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic            res_wen_q, res_wen_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     retired_q, retired_d;

  logic [XLEN-1:0] rf_rs1, rf_rs2, op_a, op_b, imm, alu_res;
  logic            is_r, is_i, legal, hz_rs1, hz_rs2, fire;
  logic [4:0]      shamt;
  alu_op_t         alu_op;

  // Only the immediate and funct7 bits of the raw word are consumed here.
  logic unused_instr;
  assign unused_instr = ^instr[29:20] ^ ^instr[19:0];

  exec_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (rs1_addr),
    .rd1      (rf_rs1),
    .ra2      (rs2_addr),
    .rd2      (rf_rs2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (res_wen_q),
    .wa       (res_rd_q),
    .wd       (result_q)
  );

  assign is_r  = (opcode == OP_RTYPE);
  assign is_i  = (opcode == OP_ITYPE);
  assign legal = is_r || is_i;
  assign imm   = {{(XLEN-12){instr[31]}}, instr[31:20]};

  // A pending write-back to a register EX is about to read; rs2 only matters for R-type.
  assign hz_rs1 = res_wen_q && (res_rd_q == rs1_addr);
  assign hz_rs2 = res_wen_q && (res_rd_q == rs2_addr) && is_r;

`ifdef EXEC_BYPASS_EN
  assign in_ready = 1'b1;
  assign op_a     = hz_rs1 ? result_q : rf_rs1;
  assign op_b     = is_r ? (hz_rs2 ? result_q : rf_rs2) : imm;
`else
  assign in_ready = !(hz_rs1 || hz_rs2);
  assign op_a     = rf_rs1;
  assign op_b     = is_r ? rf_rs2 : imm;
`endif

  assign fire   = in_valid && in_ready;
  assign alu_op = decode_alu(func, instr[30], is_r);
  assign shamt  = op_b[4:0];

  // RV32I integer ALU; all arithmetic wraps modulo 2^XLEN.
  always_comb begin
    // NOTE: give every always_comb output a default first so no path infers a latch.
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  // Next state of the WB register and the retired counter.
  always_comb begin
    res_valid_d = fire;
    res_wen_d   = fire && legal && (rd_addr != 5'd0);
    illegal_d   = fire && !legal;
    result_d    = result_q;
    res_rd_d    = res_rd_q;
    if (fire) begin
      result_d = legal ? alu_res : '0;
      res_rd_d = rd_addr;
    end
    retired_d = retired_q;
    if (res_valid_q && !illegal_q) retired_d = retired_q + 32'd1;
  end

  // WB pipeline register and counter; reset discards any in-flight write-back.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      result_q    <= '0;
      res_rd_q    <= '0;
      res_wen_q   <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      res_rd_q    <= res_rd_d;
      res_wen_q   <= res_wen_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign res_rd    = res_rd_q;
  assign res_wen   = res_wen_q;
  assign illegal   = illegal_q;
  assign retired   = retired_q;

endmodule
